// File: rtl/motion_event_uart_tx.sv
// ============================================================================
// motion_event_uart_tx : turns motion-detector rising edges into 6-byte 8N1
// UART frames (A5, seq, count[23:0], xor checksum).   Rev 1.0
// ============================================================================
`default_nettype none

module motion_event_uart_tx #(
    parameter int BAUD_DIV = 868,
    parameter int CNT_W    = 17
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             motion_detected,
    input  logic [CNT_W-1:0] diff_pixel_cnt,
    output logic             tx,
    output logic             busy,
    output logic [7:0]       event_seq,
    output logic [7:0]       drop_cnt
);

    localparam int             TW       = $clog2(BAUD_DIV);
    localparam logic [TW-1:0]  BIT_LAST = TW'(BAUD_DIV - 1);
    localparam logic [7:0]     HEADER   = 8'hA5;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t        state_q;
    logic [TW-1:0] timer_q;
    logic [2:0]    bit_idx_q;
    logic [2:0]    byte_idx_q;
    logic [23:0]   snapshot_q;
    logic [7:0]    seq_tx_q;
    logic          motion_q;
    logic          tx_q;
    logic          busy_q;
    logic [7:0]    event_seq_q;
    logic [7:0]    drop_cnt_q;

    logic          rise;
    logic          bit_end;
    logic [7:0]    checksum;
    logic [7:0]    cur_byte;

    assign rise     = motion_detected & ~motion_q;
    assign bit_end  = (timer_q == BIT_LAST);
    assign checksum = seq_tx_q ^ snapshot_q[23:16] ^ snapshot_q[15:8] ^ snapshot_q[7:0];

    always_comb begin
        cur_byte = checksum;
        case (byte_idx_q)
            3'd0:    cur_byte = HEADER;
            3'd1:    cur_byte = seq_tx_q;
            3'd2:    cur_byte = snapshot_q[23:16];
            3'd3:    cur_byte = snapshot_q[15:8];
            3'd4:    cur_byte = snapshot_q[7:0];
            default: cur_byte = checksum;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            timer_q     <= '0;
            bit_idx_q   <= '0;
            byte_idx_q  <= '0;
            snapshot_q  <= '0;
            seq_tx_q    <= '0;
            motion_q    <= 1'b0;
            tx_q        <= 1'b1;
            busy_q      <= 1'b0;
            event_seq_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            motion_q <= motion_detected;

            case (state_q)
                S_IDLE: begin
                    timer_q <= '0;
                    if (rise) begin
                        snapshot_q <= 24'(diff_pixel_cnt);
                        seq_tx_q   <= event_seq_q + 8'd1;
                        byte_idx_q <= '0;
                        bit_idx_q  <= '0;
                        tx_q       <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= S_START;
                    end
                end
                S_START: begin
                    if (bit_end) begin
                        timer_q   <= '0;
                        bit_idx_q <= '0;
                        tx_q      <= cur_byte[0];
                        state_q   <= S_DATA;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        timer_q <= '0;
                        if (bit_idx_q == 3'd7) begin
                            tx_q    <= 1'b1;
                            state_q <= S_STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                            tx_q      <= cur_byte[bit_idx_q + 3'd1];
                        end
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                S_STOP: begin
                    if (bit_end) begin
                        timer_q <= '0;
                        if (byte_idx_q == 3'd5) begin
                            busy_q      <= 1'b0;
                            event_seq_q <= seq_tx_q;
                            state_q     <= S_IDLE;
                        end else begin
                            byte_idx_q <= byte_idx_q + 3'd1;
                            tx_q       <= 1'b0;
                            state_q    <= S_START;
                        end
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase

            // busy_q is still high on the STOP->IDLE edge, so a rise there is dropped
            if (rise && busy_q && (drop_cnt_q != 8'hFF)) begin
                drop_cnt_q <= drop_cnt_q + 8'd1;
            end
        end
    end

    assign tx        = tx_q;
    assign busy      = busy_q;
    assign event_seq = event_seq_q;
    assign drop_cnt  = drop_cnt_q;

endmodule

`default_nettype wire
